// File: rtl/bram_arbiter.sv
// bram_arbiter: two-requester arbiter in front of a single-port BRAM, with a
// built-in sequencer that zeroes the whole memory on request. Read responses
// are routed back to the issuing requester through a tag pipeline that matches
// the BRAM read latency.
// Optional feature: define BRAM_ARBITER_FIXED_PRIO_EN to give requester 0
// fixed priority instead of round-robin arbitration.
module bram_arbiter #(
    parameter int P_ADDR_BITS    = 14,
    parameter int P_READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_wren,
    input  logic [P_ADDR_BITS-1:0] req_addr0,
    input  logic [P_ADDR_BITS-1:0] req_addr1,
    input  logic [31:0]            req_wdata0,
    input  logic [31:0]            req_wdata1,
    output logic [1:0]             rsp_valid,
    output logic [31:0]            rsp_data,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic                   bram_en,
    output logic                   bram_wren,
    output logic [P_ADDR_BITS-1:0] bram_addr,
    output logic [31:0]            bram_d_in,
    input  logic [31:0]            bram_d_out
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                   state_q, state_d;
    logic [P_ADDR_BITS-1:0]   clearCnt_q, clearCnt_d;
    logic                     clearDone_q, clearDone_d;
    logic                     bramEn_q, bramEn_d;
    logic                     bramWren_q, bramWren_d;
    logic [P_ADDR_BITS-1:0]   bramAddr_q, bramAddr_d;
    logic [31:0]              bramDin_q, bramDin_d;
    logic                     issueId_q, issueId_d;
    logic [P_READ_LATENCY-1:0] tagValid_q, tagValid_d;
    logic [P_READ_LATENCY-1:0] tagId_q, tagId_d;
    logic [1:0]               grant;

`ifndef BRAM_ARBITER_FIXED_PRIO_EN
    // Index of the requester that won the most recent handshake.
    logic                     rrLast_q, rrLast_d;
`endif

    // Arbitration, clear sequencing and next BRAM command selection.
    always_comb begin
        state_d     = state_q;
        clearCnt_d  = clearCnt_q;
        clearDone_d = 1'b0;
        grant       = 2'b00;
        bramEn_d    = 1'b0;
        bramWren_d  = 1'b0;
        bramAddr_d  = bramAddr_q;
        bramDin_d   = bramDin_q;
        issueId_d   = issueId_q;
`ifndef BRAM_ARBITER_FIXED_PRIO_EN
        rrLast_d    = rrLast_q;
`endif
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                end else begin
`ifdef BRAM_ARBITER_FIXED_PRIO_EN
                    if (req_valid[0]) begin
                        grant = 2'b01;
                    end else if (req_valid[1]) begin
                        grant = 2'b10;
                    end
`else
                    if (req_valid == 2'b11) begin
                        grant = rrLast_q ? 2'b01 : 2'b10;
                    end else begin
                        grant = req_valid;
                    end
                    if (grant != 2'b00) begin
                        rrLast_d = grant[1];
                    end
`endif
                    if (grant != 2'b00) begin
                        bramEn_d   = 1'b1;
                        bramWren_d = grant[1] ? req_wren[1] : req_wren[0];
                        bramAddr_d = grant[1] ? req_addr1 : req_addr0;
                        bramDin_d  = grant[1] ? req_wdata1 : req_wdata0;
                        issueId_d  = grant[1];
                    end
                end
            end
            CLEAR: begin
                bramEn_d   = 1'b1;
                bramWren_d = 1'b1;
                bramAddr_d = clearCnt_q;
                bramDin_d  = 32'd0;
                clearCnt_d = clearCnt_q + P_ADDR_BITS'(1);
                if (&clearCnt_q) begin
                    state_d     = IDLE;
                    clearDone_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tag pipeline shifts one stage per cycle; a stage enters when a read is on the BRAM port.
    always_comb begin
        tagValid_d    = '0;
        tagId_d       = '0;
        tagValid_d[0] = bramEn_q & ~bramWren_q;
        tagId_d[0]    = issueId_q;
        for (int i = 1; i < P_READ_LATENCY; i++) begin
            tagValid_d[i] = tagValid_q[i-1];
            tagId_d[i]    = tagId_q[i-1];
        end
    end

    // State, command and tag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            clearCnt_q  <= '0;
            clearDone_q <= 1'b0;
            bramEn_q    <= 1'b0;
            bramWren_q  <= 1'b0;
            bramAddr_q  <= '0;
            bramDin_q   <= '0;
            issueId_q   <= 1'b0;
            tagValid_q  <= '0;
            tagId_q     <= '0;
        end else begin
            state_q     <= state_d;
            clearCnt_q  <= clearCnt_d;
            clearDone_q <= clearDone_d;
            bramEn_q    <= bramEn_d;
            bramWren_q  <= bramWren_d;
            bramAddr_q  <= bramAddr_d;
            bramDin_q   <= bramDin_d;
            issueId_q   <= issueId_d;
            tagValid_q  <= tagValid_d;
            tagId_q     <= tagId_d;
        end
    end

`ifndef BRAM_ARBITER_FIXED_PRIO_EN
    // Round-robin pointer; starts at requester 0 so requester 1 wins the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrLast_q <= 1'b0;
        end else begin
            rrLast_q <= rrLast_d;
        end
    end
`endif

    assign req_ready  = grant;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = clearDone_q;
    assign bram_en    = bramEn_q;
    assign bram_wren  = bramWren_q;
    assign bram_addr  = bramAddr_q;
    assign bram_d_in  = bramDin_q;
    assign rsp_valid  = tagValid_q[P_READ_LATENCY-1]
                        ? (tagId_q[P_READ_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data   = tagValid_q[P_READ_LATENCY-1] ? bram_d_out : 32'd0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Testbench for bram_arbiter: 16-word BRAM model with a two-cycle read latency,
// directed vectors with hand-computed expectations.
module tb_bram_arbiter;

    localparam int AW  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_wren;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [31:0]   req_wdata0, req_wdata1;
    logic [1:0]    rsp_valid;
    logic [31:0]   rsp_data;
    logic          clear_start, clear_busy, clear_done;
    logic          bram_en, bram_wren;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_d_in, bram_d_out;

    logic [31:0]   mem [16];
    logic [31:0]   rdStage1, rdStage2;

    int checkCount = 0;
    int errorCount = 0;

`ifdef BRAM_ARBITER_FIXED_PRIO_EN
    logic [1:0]    expReady [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [3:0]    expAddr  [7] = '{4'd0, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    logic [1:0]    expRsp   [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [31:0]   expData  [7] = '{32'd0, 32'd0, 32'd0, 32'h1000_0003, 32'h1000_0003,
                                    32'h1000_0003, 32'h1000_0003};
    logic [1:0]    expBoth = 2'b01;
`else
    logic [1:0]    expReady [7] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [3:0]    expAddr  [7] = '{4'd0, 4'd7, 4'd3, 4'd7, 4'd3, 4'd3, 4'd3};
    logic [1:0]    expRsp   [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [31:0]   expData  [7] = '{32'd0, 32'd0, 32'd0, 32'h1000_0007, 32'h1000_0003,
                                    32'h1000_0007, 32'h1000_0003};
    logic [1:0]    expBoth = 2'b10;
`endif
    logic          expEn    [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    bram_arbiter #(
        .P_ADDR_BITS   (AW),
        .P_READ_LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wren   (req_wren),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .bram_en    (bram_en),
        .bram_wren  (bram_wren),
        .bram_addr  (bram_addr),
        .bram_d_in  (bram_d_in),
        .bram_d_out (bram_d_out)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Known, address-dependent contents so every read is distinguishable.
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h1000_0000 + i;
        end
    end

    // BRAM model: writes land at the sampling edge, reads appear two cycles later.
    always @(posedge clk) begin
        if (bram_en && bram_wren) begin
            mem[bram_addr] <= bram_d_in;
        end
        if (bram_en && !bram_wren) begin
            rdStage1 <= mem[bram_addr];
        end
        rdStage2 <= rdStage1;
    end
    assign bram_d_out = rdStage2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] wren,
                                 input logic [3:0] a0, input logic [3:0] a1,
                                 input logic [31:0] d0, input logic cs);
        req_valid   = valid;
        req_wren    = wren;
        req_addr0   = a0;
        req_addr1   = a1;
        req_wdata0  = d0;
        req_wdata1  = 32'h0;
        clear_start = cs;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        checkOutput("rst_clear_done", {31'd0, clear_done}, 32'd0);
        checkOutput("rst_bram_en", {31'd0, bram_en}, 32'd0);
        checkOutput("rst_bram_wren", {31'd0, bram_wren}, 32'd0);
        checkOutput("rst_bram_addr", {28'd0, bram_addr}, 32'd0);
        checkOutput("rst_bram_d_in", bram_d_in, 32'd0);

        // Both requesters hold reads for four cycles.
        for (int c = 0; c < 7; c++) begin
            applyStimulus((c < 4) ? 2'b11 : 2'b00, 2'b00, 4'd3, 4'd7, 32'd0, 1'b0);
            checkOutput($sformatf("conf_ready_c%0d", c), {30'd0, req_ready}, {30'd0, expReady[c]});
            checkOutput($sformatf("conf_en_c%0d", c), {31'd0, bram_en}, {31'd0, expEn[c]});
            if (expEn[c]) begin
                checkOutput($sformatf("conf_addr_c%0d", c), {28'd0, bram_addr}, {28'd0, expAddr[c]});
            end
            checkOutput($sformatf("conf_rsp_c%0d", c), {30'd0, rsp_valid}, {30'd0, expRsp[c]});
            checkOutput($sformatf("conf_data_c%0d", c), rsp_data, expData[c]);
            tick();
        end

        // Write 0xDEADBEEF to 0x10 (aliases to 0 with 4 address bits), read it back next cycle.
        applyStimulus(2'b01, 2'b01, 4'd0, 4'd0, 32'hDEADBEEF, 1'b0);
        checkOutput("wr_ready", {30'd0, req_ready}, 32'd1);
        tick();
        checkOutput("wr_en", {31'd0, bram_en}, 32'd1);
        checkOutput("wr_wren", {31'd0, bram_wren}, 32'd1);
        checkOutput("wr_d_in", bram_d_in, 32'hDEADBEEF);
        applyStimulus(2'b01, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("rd_ready", {30'd0, req_ready}, 32'd1);
        tick();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("rd_en", {31'd0, bram_en}, 32'd1);
        checkOutput("rd_wren", {31'd0, bram_wren}, 32'd0);
        checkOutput("wr_no_rsp", {30'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("rd_rsp_early", {30'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("rd_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        checkOutput("rd_rsp_data", rsp_data, 32'hDEADBEEF);
        tick();

        // Read from requester 1, then clear_start together with both requests.
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd5, 32'd0, 1'b0);
        checkOutput("pre_clr_ready", {30'd0, req_ready}, 32'd2);
        tick();
        applyStimulus(2'b11, 2'b00, 4'd0, 4'd5, 32'd0, 1'b1);
        checkOutput("clr_beats_req", {30'd0, req_ready}, 32'd0);
        checkOutput("pre_clr_rd_addr", {28'd0, bram_addr}, 32'd5);
        tick();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("clr_busy", {31'd0, clear_busy}, 32'd1);
        checkOutput("clr_rsp_pending", {30'd0, rsp_valid}, 32'd0);
        tick();
        checkOutput("inflight_rsp", {30'd0, rsp_valid}, 32'd2);
        checkOutput("inflight_data", rsp_data, 32'h1000_0005);
        for (int k = 0; k < 16; k++) begin
            applyStimulus((k == 2) ? 2'b01 : 2'b00, 2'b00, 4'd0, 4'd0, 32'd0, k == 2);
            if (k == 2) begin
                checkOutput("clr_ready_blocked", {30'd0, req_ready}, 32'd0);
            end
            checkOutput($sformatf("clr_en_%0d", k), {31'd0, bram_en}, 32'd1);
            checkOutput($sformatf("clr_wren_%0d", k), {31'd0, bram_wren}, 32'd1);
            checkOutput($sformatf("clr_addr_%0d", k), {28'd0, bram_addr}, k);
            checkOutput($sformatf("clr_din_%0d", k), bram_d_in, 32'd0);
            checkOutput($sformatf("clr_done_%0d", k), {31'd0, clear_done}, {31'd0, k == 15});
            checkOutput($sformatf("clr_busy_%0d", k), {31'd0, clear_busy}, {31'd0, k != 15});
            tick();
        end
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("post_clr_done", {31'd0, clear_done}, 32'd0);
        checkOutput("post_clr_en", {31'd0, bram_en}, 32'd0);
        checkOutput("post_clr_busy", {31'd0, clear_busy}, 32'd0);
        applyStimulus(2'b01, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("alias_rd_ready", {30'd0, req_ready}, 32'd1);
        tick();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();
        tick();
        checkOutput("alias_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        checkOutput("alias_rsp_data", rsp_data, 32'd0);
        tick();

        // Move the pointer to requester 1, then reset in the middle of a clear.
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd2, 32'd0, 1'b0);
        checkOutput("ptr_ready", {30'd0, req_ready}, 32'd2);
        tick();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b1);
        tick();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
        end
        checkOutput("abort_addr4", {28'd0, bram_addr}, 32'd4);
        checkOutput("abort_busy_before", {31'd0, clear_busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        checkOutput("abort_en", {31'd0, bram_en}, 32'd0);
        checkOutput("abort_busy", {31'd0, clear_busy}, 32'd0);
        checkOutput("abort_done", {31'd0, clear_done}, 32'd0);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput($sformatf("abort_no_done_%0d", j), {31'd0, clear_done}, 32'd0);
        end
        applyStimulus(2'b11, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("ptr_reset_ready", {30'd0, req_ready}, {30'd0, expBoth});
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        tick();

        // A read in flight at reset must never respond.
        applyStimulus(2'b01, 2'b00, 4'd1, 4'd0, 32'd0, 1'b0);
        checkOutput("flush_ready", {30'd0, req_ready}, 32'd1);
        tick();
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 32'd0, 1'b0);
        checkOutput("flush_en", {31'd0, bram_en}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checkOutput($sformatf("flush_rsp_%0d", j), {30'd0, rsp_valid}, 32'd0);
            checkOutput($sformatf("flush_data_%0d", j), rsp_data, 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
